// File: rtl/shear_ctrl.sv
// rtl/shear_ctrl.sv - shear-sort sequencer for one PE of a SIDE x SIDE mesh
// Emits partner select, min/max choice and commit strobes through alternating row/column phases.
module shear_ctrl #(
  parameter int SIDE        = 4,
  parameter int I           = 0,
  parameter int SORT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  output logic [2:0] o_sel,
  output logic       o_keep_min,
  output logic       o_step,
  output logic       o_col,
  output logic       o_busy,
  output logic       o_done
);

  localparam int LOG     = $clog2(SIDE);
  localparam int TW      = (LOG > 0) ? LOG : 1;
  localparam int CW      = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
  localparam int PH_LAST = 2 * LOG;
  localparam int PW      = $clog2(2 * LOG + 1) + 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(SORT_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(SIDE - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(PH_LAST);

  localparam int  ROW_IDX   = I / SIDE;
  localparam int  COL_IDX   = I % SIDE;
  localparam bit  ROW_ODD   = (ROW_IDX % 2) == 1;
  localparam bit  COL_ODD   = (COL_IDX % 2) == 1;
  localparam bit  ROW_HAS_D = (ROW_IDX + 1) < SIDE;
  localparam bit  ROW_HAS_U = ROW_IDX > 0;
  localparam bit  COL_HAS_R = (COL_IDX + 1) < SIDE;
  localparam bit  COL_HAS_L = COL_IDX > 0;

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cyc;
  logic [TW-1:0] r_t;
  logic [PW-1:0] r_ph;

  logic w_run, w_last_cyc, w_step_end, w_phase_end;
  logic w_odd, w_has_fwd, w_has_back, w_fwd, w_back;

  assign w_run       = (r_state == S_ROW) || (r_state == S_COL);
  assign w_last_cyc  = (r_cyc == CYC_LAST);
  assign w_step_end  = w_run && w_last_cyc;
  assign w_phase_end = w_step_end && (r_t == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= '0;
      r_t   <= '0;
      r_ph  <= '0;
    end else if (w_run) begin
      r_cyc <= w_last_cyc ? '0 : r_cyc + 1'b1;
      if (w_step_end) r_t <= (r_t == T_LAST) ? '0 : r_t + 1'b1;
      if (w_phase_end) r_ph <= r_ph + 1'b1;
    end else begin
      r_cyc <= '0;
      r_t   <= '0;
      r_ph  <= '0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_ROW;
      S_ROW:  if (w_phase_end) w_next = (r_ph == P_LAST) ? S_DONE : S_COL;
      S_COL:  if (w_phase_end) w_next = S_ROW;
      S_DONE: w_next = i_start ? S_ROW : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Partner is "forward" (R/D) when position and step share parity, otherwise "back" (L/U).
  always_comb begin
    w_odd      = (r_state == S_COL) ? ROW_ODD   : COL_ODD;
    w_has_fwd  = (r_state == S_COL) ? ROW_HAS_D : COL_HAS_R;
    w_has_back = (r_state == S_COL) ? ROW_HAS_U : COL_HAS_L;
    w_fwd      = (w_odd == r_t[0]) && w_has_fwd;
    w_back     = (w_odd != r_t[0]) && w_has_back;
  end

  always_comb begin
    o_sel      = 3'd0;
    o_keep_min = 1'b0;
    o_step     = 1'b0;
    o_col      = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_ROW: begin
        o_busy = 1'b1;
        o_step = w_last_cyc;
        if (w_fwd) begin
          o_sel      = 3'd2;
          o_keep_min = !ROW_ODD;
        end else if (w_back) begin
          o_sel      = 3'd1;
          o_keep_min = ROW_ODD;
        end
      end
      S_COL: begin
        o_busy = 1'b1;
        o_col  = 1'b1;
        o_step = w_last_cyc;
        if (w_fwd) begin
          o_sel      = 3'd4;
          o_keep_min = 1'b1;
        end else if (w_back) begin
          o_sel = 3'd3;
        end
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shear_ctrl.sv
// tb/tb_shear_ctrl.sv - randomized bench for shear_ctrl against a step-index reference model
// Three PE configurations share clk/rst/i_start; each has its own model.
module tb_shear_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;

  logic [2:0] sel [3];
  logic       km [3], stp [3], col [3], busy [3], done [3];

  shear_ctrl #(.SIDE(2), .I(0), .SORT_CYCLES(1)) u_d0 (
    .clk(clk), .rst(rst), .i_start(i_start), .o_sel(sel[0]), .o_keep_min(km[0]),
    .o_step(stp[0]), .o_col(col[0]), .o_busy(busy[0]), .o_done(done[0]));
  shear_ctrl #(.SIDE(2), .I(3), .SORT_CYCLES(1)) u_d1 (
    .clk(clk), .rst(rst), .i_start(i_start), .o_sel(sel[1]), .o_keep_min(km[1]),
    .o_step(stp[1]), .o_col(col[1]), .o_busy(busy[1]), .o_done(done[1]));
  shear_ctrl #(.SIDE(4), .I(5), .SORT_CYCLES(3)) u_d2 (
    .clk(clk), .rst(rst), .i_start(i_start), .o_sel(sel[2]), .o_keep_min(km[2]),
    .o_step(stp[2]), .o_col(col[2]), .o_busy(busy[2]), .o_done(done[2]));

  always #5 clk = ~clk;

  int p_side [3] = '{2, 2, 4};
  int p_idx  [3] = '{0, 3, 5};
  int p_sc   [3] = '{1, 1, 3};

  // mode: 0 idle, 1 sorting at busy-cycle k, 2 done cycle
  int m_mode [3];
  int m_k    [3];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got sel/km/step/col/busy/done=%b required %b", tag, got, exp);
    end
  endtask

  function automatic int total_cycles(input int d);
    return (2 * $clog2(p_side[d]) + 1) * p_side[d] * p_sc[d];
  endfunction

  function automatic logic [7:0] expected(input int d);
    logic [2:0] e_sel = 3'd0;
    logic e_km = 0, e_step = 0, e_col = 0, e_busy = 0, e_done = 0;
    int side = p_side[d];
    int s, ph, t, pos, dir, pp;
    if (m_mode[d] == 2) e_done = 1;
    if (m_mode[d] == 1) begin
      e_busy = 1;
      e_step = (m_k[d] % p_sc[d]) == p_sc[d] - 1;
      s   = m_k[d] / p_sc[d];
      ph  = s / side;
      t   = s % side;
      e_col = (ph % 2) == 1;
      pos = e_col ? p_idx[d] / side : p_idx[d] % side;
      dir = ((pos + t) % 2 == 0) ? 1 : -1;
      pp  = pos + dir;
      if (pp >= 0 && pp < side) begin
        if (e_col) begin
          e_sel = (dir > 0) ? 3'd4 : 3'd3;
          e_km  = dir > 0;
        end else begin
          e_sel = (dir > 0) ? 3'd2 : 3'd1;
          e_km  = (dir > 0) ^ ((p_idx[d] / side) % 2 == 1);
        end
      end
    end
    return {e_sel, e_km, e_step, e_col, e_busy, e_done};
  endfunction

  task automatic model_clock(input logic start);
    for (int d = 0; d < 3; d++) begin
      case (m_mode[d])
        0: if (start) begin m_mode[d] = 1; m_k[d] = 0; end
        1: begin
          m_k[d]++;
          if (m_k[d] == total_cycles(d)) m_mode[d] = 2;
        end
        default: if (start) begin m_mode[d] = 1; m_k[d] = 0; end else m_mode[d] = 0;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_mode[d] = 0;
      m_k[d] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s_d%0d", tag, d),
            {sel[d], km[d], stp[d], col[d], busy[d], done[d]}, expected(d));
  endtask

  initial begin
    int seg_kind;
    model_reset();
    #2;
    check_all("reset_async");
    repeat (2) @(negedge clk);
    check_all("reset_hold");
    rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 200 == 0) seg_kind = $urandom_range(0, 2);
      @(posedge clk);
      model_clock(i_start);
      @(negedge clk);
      check_all("run");
      if ($urandom_range(0, 99) < 2) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("rst_mid");
        #1 rst = 1'b0;
      end
      case (seg_kind)
        0: i_start = 1'b1;
        1: i_start = ($urandom_range(0, 29) == 0);
        default: i_start = $urandom_range(0, 1);
      endcase
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
